// File: rtl/reg_sequencer.sv
// Byte-stream register sequencer: fetches one-byte instructions, drives an external
// 4x8 register file through combinational read ports and one write port.
module reg_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] instr,
    input  logic       instr_valid,
    output logic       instr_ready,
    output logic [1:0] rf_in_1,
    output logic [1:0] rf_in_2,
    output logic       rf_wen,
    output logic [7:0] rf_data,
    input  logic [7:0] rf_out_1,
    input  logic [7:0] rf_out_2,
    output logic       flag_z,
    output logic       flag_c,
    output logic       halted,
    output logic       illegal,
    output logic [7:0] retired
);

    typedef enum logic [1:0] {FETCH, EXEC, IMM, HALT} state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_MOV = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_LDI = 4'h7;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic [1:0] rd_hold_q, rd_hold_d;
    logic [1:0] rs_hold_q, rs_hold_d;
    logic       flag_z_q, flag_z_d;
    logic       flag_c_q, flag_c_d;
    logic       illegal_q, illegal_d;
    logic [7:0] retired_q, retired_d;

    logic [3:0] ir_op;
    logic [1:0] ir_rd;
    logic [1:0] ir_rs;
    logic [7:0] alu_res;
    logic       alu_c;
    logic       alu_sets_flags;
    logic [8:0] sum9;

    assign ir_op = ir_q[7:4];
    assign ir_rd = ir_q[3:2];
    assign ir_rs = ir_q[1:0];
    assign sum9  = {1'b0, rf_out_1} + {1'b0, rf_out_2};

    always_comb begin
        alu_res        = 8'h00;
        alu_c          = 1'b0;
        alu_sets_flags = 1'b1;
        case (ir_op)
            OP_MOV: begin
                alu_res        = rf_out_2;
                alu_sets_flags = 1'b0;
            end
            OP_ADD: {alu_c, alu_res} = sum9;
            OP_SUB: begin
                alu_res = rf_out_1 - rf_out_2;
                alu_c   = (rf_out_1 < rf_out_2);
            end
            OP_AND: alu_res = rf_out_1 & rf_out_2;
            OP_OR:  alu_res = rf_out_1 | rf_out_2;
            OP_XOR: alu_res = rf_out_1 ^ rf_out_2;
            default: alu_sets_flags = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        rd_hold_d   = rd_hold_q;
        rs_hold_d   = rs_hold_q;
        flag_z_d    = flag_z_q;
        flag_c_d    = flag_c_q;
        illegal_d   = 1'b0;
        retired_d   = retired_q;
        instr_ready = 1'b0;
        rf_wen      = 1'b0;
        rf_data     = alu_res;
        rf_in_1     = rd_hold_q;
        rf_in_2     = rs_hold_q;
        case (state_q)
            FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    ir_d = instr;
                    case (instr[7:4])
                        OP_NOP: retired_d = retired_q + 8'd1;
                        OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state_d = EXEC;
                        OP_LDI: state_d = IMM;
                        OP_HLT: begin
                            state_d   = HALT;
                            retired_d = retired_q + 8'd1;
                        end
                        default: begin
                            illegal_d = 1'b1;
                            retired_d = retired_q + 8'd1;
                        end
                    endcase
                end
            end
            EXEC: begin
                rf_in_1   = ir_rd;
                rf_in_2   = ir_rs;
                rd_hold_d = ir_rd;
                rs_hold_d = ir_rs;
                rf_wen    = 1'b1;
                retired_d = retired_q + 8'd1;
                state_d   = FETCH;
                if (alu_sets_flags) begin
                    flag_z_d = (alu_res == 8'h00);
                    flag_c_d = alu_c;
                end
            end
            IMM: begin
                instr_ready = 1'b1;
                rf_in_1     = ir_rd;
                rd_hold_d   = ir_rd;
                rf_data     = instr;
                rf_wen      = instr_valid;
                if (instr_valid) begin
                    retired_d = retired_q + 8'd1;
                    state_d   = FETCH;
                end
            end
            default: ;
        endcase
        // Reset lands the FSM in FETCH immediately; keep the handshake and write quiet until release.
        if (rst) begin
            instr_ready = 1'b0;
            rf_wen      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            ir_q      <= 8'h00;
            rd_hold_q <= 2'd0;
            rs_hold_q <= 2'd0;
            flag_z_q  <= 1'b0;
            flag_c_q  <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            rd_hold_q <= rd_hold_d;
            rs_hold_q <= rs_hold_d;
            flag_z_q  <= flag_z_d;
            flag_c_q  <= flag_c_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    assign flag_z  = flag_z_q;
    assign flag_c  = flag_c_q;
    assign halted  = (state_q == HALT);
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_reg_sequencer.sv
// Directed bench for reg_sequencer: register-file read data is driven directly,
// expected values are hand-computed per vector.
module tb_reg_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] instr = 8'h00;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [1:0] rf_in_1;
    logic [1:0] rf_in_2;
    logic       rf_wen;
    logic [7:0] rf_data;
    logic [7:0] rf_out_1 = 8'h00;
    logic [7:0] rf_out_2 = 8'h00;
    logic       flag_z;
    logic       flag_c;
    logic       halted;
    logic       illegal;
    logic [7:0] retired;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_ret = 8'h00;

    reg_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .rf_in_1     (rf_in_1),
        .rf_in_2     (rf_in_2),
        .rf_wen      (rf_wen),
        .rf_data     (rf_data),
        .rf_out_1    (rf_out_1),
        .rf_out_2    (rf_out_2),
        .flag_z      (flag_z),
        .flag_c      (flag_c),
        .halted      (halted),
        .illegal     (illegal),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_ready", 16'(instr_ready), 16'h0);
        check_eq("rst_wen", 16'(rf_wen), 16'h0);
        check_eq("rst_rf1", 16'(rf_in_1), 16'h0);
        check_eq("rst_rf2", 16'(rf_in_2), 16'h0);
        check_eq("rst_flags", 16'({flag_z, flag_c}), 16'h0);
        check_eq("rst_halted", 16'(halted), 16'h0);
        check_eq("rst_illegal", 16'(illegal), 16'h0);
        check_eq("rst_retired", 16'(retired), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        exp_ret = 8'h00;
        #1;
        check_eq("post_rst_ready", 16'(instr_ready), 16'h1);
    endtask

    task automatic send_fetch(input logic [7:0] b);
        @(negedge clk);
        instr       = b;
        instr_valid = 1'b1;
        #1;
        check_eq("fetch_ready", 16'(instr_ready), 16'h1);
        check_eq("fetch_wen", 16'(rf_wen), 16'h0);
    endtask

    task automatic alu_op(input logic [7:0] b, input logic [7:0] a1, input logic [7:0] a2,
                          input logic [7:0] exp_data, input logic ez, input logic ec);
        send_fetch(b);
        @(negedge clk);
        instr_valid = 1'b0;
        rf_out_1    = a1;
        rf_out_2    = a2;
        #1;
        check_eq("exec_ready", 16'(instr_ready), 16'h0);
        check_eq("exec_wen", 16'(rf_wen), 16'h1);
        check_eq("exec_data", 16'(rf_data), 16'(exp_data));
        check_eq("exec_rf1", 16'(rf_in_1), 16'(b[3:2]));
        check_eq("exec_rf2", 16'(rf_in_2), 16'(b[1:0]));
        @(negedge clk);
        #1;
        exp_ret = exp_ret + 8'd1;
        check_eq("alu_retired", 16'(retired), 16'(exp_ret));
        check_eq("alu_flag_z", 16'(flag_z), 16'(ez));
        check_eq("alu_flag_c", 16'(flag_c), 16'(ec));
        check_eq("alu_after_wen", 16'(rf_wen), 16'h0);
        check_eq("alu_after_ready", 16'(instr_ready), 16'h1);
        check_eq("alu_hold_rf1", 16'(rf_in_1), 16'(b[3:2]));
        check_eq("alu_hold_rf2", 16'(rf_in_2), 16'(b[1:0]));
    endtask

    initial begin
        do_reset();

        // LDI r3,0x17
        send_fetch(8'h7C);
        @(negedge clk);
        instr = 8'h17;
        #1;
        check_eq("ldi_wen", 16'(rf_wen), 16'h1);
        check_eq("ldi_rf1", 16'(rf_in_1), 16'h3);
        check_eq("ldi_data", 16'(rf_data), 16'h17);
        check_eq("ldi_ready", 16'(instr_ready), 16'h1);
        @(negedge clk);
        instr_valid = 1'b0;
        #1;
        exp_ret = exp_ret + 8'd1;
        check_eq("ldi_retired", 16'(retired), 16'(exp_ret));
        check_eq("ldi_after_wen", 16'(rf_wen), 16'h0);

        //      instr  rf_out_1 rf_out_2 result z  c
        alu_op(8'h2D, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b1); // ADD r3,r1 carry out
        alu_op(8'h30, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0); // SUB r0,r0
        alu_op(8'h16, 8'h77, 8'hAB, 8'hAB, 1'b1, 1'b0); // MOV r1,r2 keeps flags
        alu_op(8'h3B, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1); // SUB borrow
        alu_op(8'h41, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0); // AND
        alu_op(8'h56, 8'h0F, 8'h30, 8'h3F, 1'b0, 1'b0); // OR
        alu_op(8'h6F, 8'h55, 8'h55, 8'h00, 1'b1, 1'b0); // XOR r3,r3
        alu_op(8'h25, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1); // ADD r1,r1 wraps
        alu_op(8'h1B, 8'h00, 8'h42, 8'h42, 1'b1, 1'b1); // MOV r2,r3 keeps flags

        // Illegal opcode 0x9A
        send_fetch(8'h9A);
        @(negedge clk);
        instr_valid = 1'b0;
        #1;
        exp_ret = exp_ret + 8'd1;
        check_eq("ill_pulse", 16'(illegal), 16'h1);
        check_eq("ill_wen", 16'(rf_wen), 16'h0);
        check_eq("ill_ready", 16'(instr_ready), 16'h1);
        check_eq("ill_retired", 16'(retired), 16'(exp_ret));
        check_eq("ill_hold_rf1", 16'(rf_in_1), 16'h2);
        check_eq("ill_hold_rf2", 16'(rf_in_2), 16'h3);
        check_eq("ill_flags", 16'({flag_z, flag_c}), 16'h3);
        @(negedge clk);
        #1;
        check_eq("ill_drop", 16'(illegal), 16'h0);

        // NOP
        send_fetch(8'h00);
        @(negedge clk);
        instr_valid = 1'b0;
        #1;
        exp_ret = exp_ret + 8'd1;
        check_eq("nop_retired", 16'(retired), 16'(exp_ret));
        check_eq("nop_illegal", 16'(illegal), 16'h0);
        check_eq("nop_ready", 16'(instr_ready), 16'h1);

        // LDI r1 with a 5-cycle stall on the immediate
        send_fetch(8'h74);
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("stall_wen", 16'(rf_wen), 16'h0);
            check_eq("stall_ready", 16'(instr_ready), 16'h1);
            check_eq("stall_retired", 16'(retired), 16'(exp_ret));
            @(negedge clk);
        end
        instr       = 8'h99;
        instr_valid = 1'b1;
        #1;
        check_eq("stall_write_wen", 16'(rf_wen), 16'h1);
        check_eq("stall_write_data", 16'(rf_data), 16'h99);
        check_eq("stall_write_rf1", 16'(rf_in_1), 16'h1);
        @(negedge clk);
        instr_valid = 1'b0;
        #1;
        exp_ret = exp_ret + 8'd1;
        check_eq("stall_retired_end", 16'(retired), 16'(exp_ret));

        // HLT with instr_valid held high afterwards
        send_fetch(8'hF0);
        exp_ret = exp_ret + 8'd1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            instr       = 8'h2D;
            instr_valid = 1'b1;
            #1;
            check_eq("hlt_halted", 16'(halted), 16'h1);
            check_eq("hlt_ready", 16'(instr_ready), 16'h0);
            check_eq("hlt_wen", 16'(rf_wen), 16'h0);
            check_eq("hlt_retired", 16'(retired), 16'(exp_ret));
        end

        // Reset mid-EXEC aborts the ADD
        do_reset();
        send_fetch(8'h2D);
        @(negedge clk);
        instr_valid = 1'b0;
        rf_out_1    = 8'hF0;
        rf_out_2    = 8'h20;
        #1;
        check_eq("abort_exec_wen", 16'(rf_wen), 16'h1);
        rst = 1'b1;
        #1;
        check_eq("abort_wen", 16'(rf_wen), 16'h0);
        check_eq("abort_ready", 16'(instr_ready), 16'h0);
        check_eq("abort_retired", 16'(retired), 16'h0);
        check_eq("abort_rf1", 16'(rf_in_1), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("abort_post_ready", 16'(instr_ready), 16'h1);
        check_eq("abort_post_retired", 16'(retired), 16'h0);
        check_eq("abort_post_flags", 16'({flag_z, flag_c}), 16'h0);
        check_eq("abort_post_halted", 16'(halted), 16'h0);

        // Retired counter wrap with back-to-back NOPs
        do_reset();
        @(negedge clk);
        instr       = 8'h00;
        instr_valid = 1'b1;
        repeat (255) @(negedge clk);
        #1;
        check_eq("wrap_255", 16'(retired), 16'hFF);
        @(negedge clk);
        instr_valid = 1'b0;
        #1;
        check_eq("wrap_0", 16'(retired), 16'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
